// File: rtl/uart_ctrl_unit.sv
// UART control unit: turns send/read requests from the control register into
// TX FIFO draining, single-byte RX reads, and RX FIFO pushes from the receiver.
module uart_ctrl_unit #(
  parameter int DATA_W    = 8,
  parameter int CNT_WIDTH = 9,
  parameter int MAX_BURST = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_send_req,
  input  logic                 i_read_req,
  output logic                 o_clear_send,
  output logic                 o_clear_read,
  input  logic                 i_tx_fifo_empty,
  output logic                 o_tx_fifo_pop,
  input  logic [DATA_W-1:0]    i_tx_fifo_data,
  output logic                 o_tx_start,
  output logic [DATA_W-1:0]    o_tx_data,
  input  logic                 i_tx_done,
  input  logic                 i_rx_valid,
  input  logic [DATA_W-1:0]    i_rx_data,
  input  logic                 i_rx_fifo_full,
  input  logic                 i_rx_fifo_empty,
  output logic                 o_rx_fifo_push,
  output logic [DATA_W-1:0]    o_rx_fifo_wdata,
  output logic                 o_rx_fifo_pop,
  input  logic [DATA_W-1:0]    i_rx_fifo_data,
  output logic                 o_rd_data_we,
  output logic [DATA_W-1:0]    o_rd_data,
  input  logic                 i_overrun_clr,
  output logic                 o_rx_overrun,
  output logic                 o_tx_busy,
  output logic [CNT_WIDTH-1:0] o_tx_sent_cnt
);

  typedef enum logic [2:0] {TX_IDLE, TX_POP, TX_LOAD, TX_WAIT, TX_DONE} tx_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_POP, RD_LATCH, RD_CLR} rd_state_e;

  localparam logic [CNT_WIDTH-1:0] BURST_CNT = CNT_WIDTH'(MAX_BURST);

  tx_state_e             tx_state, tx_next;
  rd_state_e             rd_state, rd_next;
  logic [DATA_W-1:0]     tx_data_q, rd_data_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  ovr_q;
  logic                  burst_hit;

  assign burst_hit = (MAX_BURST != 0) && (cnt_q == BURST_CNT);

  // ---------------- TX path ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state  <= TX_IDLE;
      tx_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE && i_send_req)
        cnt_q <= '0;
      else if (tx_state == TX_LOAD && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
      if (tx_state == TX_LOAD)
        tx_data_q <= i_tx_fifo_data;
    end
  end

  // A dropped request stops the burst once the in-flight byte is done.
  always_comb begin
    tx_next       = tx_state;
    o_tx_fifo_pop = 1'b0;
    o_tx_start    = 1'b0;
    o_clear_send  = 1'b0;
    case (tx_state)
      TX_IDLE: if (i_send_req) tx_next = i_tx_fifo_empty ? TX_DONE : TX_POP;
      TX_POP: begin
        o_tx_fifo_pop = 1'b1;
        tx_next       = TX_LOAD;
      end
      TX_LOAD: begin
        o_tx_start = 1'b1;
        tx_next    = TX_WAIT;
      end
      TX_WAIT: if (i_tx_done)
        tx_next = (i_tx_fifo_empty || burst_hit || !i_send_req) ? TX_DONE : TX_POP;
      TX_DONE: begin
        o_clear_send = 1'b1;
        tx_next      = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // FIFO data arrives during LOAD, so it is forwarded alongside the start
  // strobe and then held from the register while the byte is on the wire.
  assign o_tx_data     = (tx_state == TX_LOAD) ? i_tx_fifo_data : tx_data_q;
  assign o_tx_busy     = (tx_state != TX_IDLE);
  assign o_tx_sent_cnt = cnt_q;

  // ---------------- Read path ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_state  <= RD_IDLE;
      rd_data_q <= '0;
    end else begin
      rd_state <= rd_next;
      if (rd_state == RD_LATCH)
        rd_data_q <= i_rx_fifo_data;
    end
  end

  always_comb begin
    rd_next       = rd_state;
    o_rx_fifo_pop = 1'b0;
    o_rd_data_we  = 1'b0;
    o_clear_read  = 1'b0;
    case (rd_state)
      RD_IDLE: if (i_read_req) rd_next = i_rx_fifo_empty ? RD_CLR : RD_POP;
      RD_POP: begin
        o_rx_fifo_pop = 1'b1;
        rd_next       = RD_LATCH;
      end
      RD_LATCH: begin
        o_rd_data_we = 1'b1;
        rd_next      = RD_CLR;
      end
      RD_CLR: begin
        o_clear_read = 1'b1;
        rd_next      = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  assign o_rd_data = (rd_state == RD_LATCH) ? i_rx_fifo_data : rd_data_q;

  // ---------------- RX push ----------------
  assign o_rx_fifo_push  = i_rx_valid & ~i_rx_fifo_full;
  assign o_rx_fifo_wdata = i_rx_data;

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       ovr_q <= 1'b0;
    else if (i_rx_valid && i_rx_fifo_full) ovr_q <= 1'b1;
    else if (i_overrun_clr)             ovr_q <= 1'b0;
  end

  assign o_rx_overrun = ovr_q;

endmodule
